// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master drives start/bin_in; slave returns busy/done/bcd_out/ovf.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, reset (sync, active-low), bus (slave: start/bin_in in, busy/done/bcd_out/ovf out).
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BW   = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int CW   = $clog2(BIN_W + 1);

  // Only selected when bin_in exceeds MAXV, so MAXV fits BIN_W then.
  localparam logic [BIN_W-1:0] MAXV_B = BIN_W'(MAXV);
  localparam logic [CW-1:0]    LAST   = CW'(BIN_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] op_q, op_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [31:0]      bin_ext;
  logic             over;
  logic [BW-1:0]    adj;

  assign bin_ext = 32'(bus.bin_in);
  assign over    = bin_ext > 32'(MAXV);

  // Add-3 on every digit >= 5 ahead of the shift; no inter-digit carry.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = over ? MAXV_B : bus.bin_in;
          pend_d  = over;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, op_d} = {adj, op_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = scr_q;
        ovf_d   = pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (16-bit and 12-bit builds).
// Reference model uses decimal arithmetic on saturated values.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) b16();
  bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) b12();

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .bus(b16.slave)
  );
  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut12 (
    .clk(clk), .reset(reset), .bus(b12.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  // Drives one conversion and gathers what came back; no checking here.
  task automatic run_conv(input int v, input bit aligned,
                          input int poke_at, input int poke_v,
                          output int lat, output logic [15:0] bcd,
                          output logic ovf, output int busy_err);
    if (!aligned) @(negedge clk);
    b16.start  = 1'b1;
    b16.bin_in = 16'(v);
    @(posedge clk); #1;
    b16.start = 1'b0;
    lat = 0;
    busy_err = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (b16.done) begin
        lat = c;
        if (b16.busy) busy_err++;
        break;
      end
      if (!b16.busy) busy_err++;
      if (c == poke_at) begin
        b16.start  = 1'b1;
        b16.bin_in = 16'(poke_v);
      end else begin
        b16.start = 1'b0;
      end
    end
    b16.start = 1'b0;
    bcd = b16.bcd_out;
    ovf = b16.ovf;
  endtask

  task automatic test_reset();
    b16.start = 1'b0; b16.bin_in = '0;
    b12.start = 1'b0; b12.bin_in = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (b16.busy !== 1'b0 || b16.done !== 1'b0 ||
        b16.bcd_out !== 16'h0 || b16.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16: busy=%b done=%b bcd=%h ovf=%b want 0 0 0000 0",
               b16.busy, b16.done, b16.bcd_out, b16.ovf);
    end
    n_chk++;
    if (b12.busy !== 1'b0 || b12.done !== 1'b0 ||
        b12.bcd_out !== 16'h0 || b12.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset12: busy=%b done=%b bcd=%h ovf=%b want 0 0 0000 0",
               b12.busy, b12.done, b12.bcd_out, b12.ovf);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_values(input string tag, input int vals[]);
    int lat, be;
    logic [15:0] bcd;
    logic ov;
    foreach (vals[k]) begin
      run_conv(vals[k], 1'b0, 0, 0, lat, bcd, ov, be);
      n_chk++;
      if (bcd !== ref_bcd(vals[k])) begin
        n_fail++;
        $display("FAIL %s_bcd(%0d): got %h want %h", tag, vals[k], bcd,
                 ref_bcd(vals[k]));
      end
      n_chk++;
      if (ov !== (vals[k] > 9999)) begin
        n_fail++;
        $display("FAIL %s_ovf(%0d): got %b want %b", tag, vals[k], ov,
                 vals[k] > 9999);
      end
      n_chk++;
      if (lat != 17 || be != 0) begin
        n_fail++;
        $display("FAIL %s_timing(%0d): latency %0d busy_errs %0d want 17 0",
                 tag, vals[k], lat, be);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, be, nd;
    logic [15:0] bcd;
    logic ov;
    run_conv(500, 1'b0, 5, 777, lat, bcd, ov, be);
    n_chk++;
    if (bcd !== 16'h0500 || lat != 17 || be != 0) begin
      n_fail++;
      $display("FAIL ignore_mid: bcd %h lat %0d busy_errs %0d want 0500 17 0",
               bcd, lat, be);
    end
    run_conv(777, 1'b1, 0, 0, lat, bcd, ov, be);
    n_chk++;
    if (bcd !== 16'h0777 || ov !== 1'b0 || lat != 17 || be != 0) begin
      n_fail++;
      $display("FAIL back_to_back: bcd %h ovf %b lat %0d be %0d want 0777 0 17 0",
               bcd, ov, lat, be);
    end
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b16.done) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL extra_done: got %0d want 0", nd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, be, nd;
    logic [15:0] bcd;
    logic ov;
    run_conv(65535, 1'b0, 0, 0, lat, bcd, ov, be);
    @(negedge clk);
    b16.start = 1'b1; b16.bin_in = 16'd4321;
    @(posedge clk); #1;
    b16.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (b16.busy !== 1'b0 || b16.done !== 1'b0 ||
        b16.bcd_out !== 16'h0 || b16.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b want 0 0 0000 0",
               b16.busy, b16.done, b16.bcd_out, b16.ovf);
    end
    reset = 1'b1;
    nd = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (b16.done || b16.busy) nd++;
    end
    n_chk++;
    if (nd != 0 || b16.bcd_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_discard: activity %0d bcd %h want 0 0000",
               nd, b16.bcd_out);
    end
    run_conv(4321, 1'b0, 0, 0, lat, bcd, ov, be);
    n_chk++;
    if (bcd !== 16'h4321 || ov !== 1'b0 || lat != 17) begin
      n_fail++;
      $display("FAIL after_reset: bcd %h ovf %b lat %0d want 4321 0 17",
               bcd, ov, lat);
    end
  endtask

  task automatic test_bin12();
    int vals[2] = '{4095, 2748};
    int lat;
    foreach (vals[k]) begin
      @(negedge clk);
      b12.start = 1'b1; b12.bin_in = 12'(vals[k]);
      @(posedge clk); #1;
      b12.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (b12.done) begin lat = c; break; end
      end
      n_chk++;
      if (lat != 13 || b12.bcd_out !== ref_bcd(vals[k]) || b12.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL bin12(%0d): bcd %h ovf %b lat %0d want %h 0 13",
                 vals[k], b12.bcd_out, b12.ovf, lat, ref_bcd(vals[k]));
      end
    end
  endtask

  task automatic test_random();
    int v, lat, be;
    logic [15:0] bcd;
    logic ov;
    for (int k = 0; k < 40; k++) begin
      v = (k % 4 == 0) ? int'($urandom_range(9990, 10010))
                       : int'($urandom_range(0, 65535));
      run_conv(v, 1'b0, 0, 0, lat, bcd, ov, be);
      n_chk++;
      if (bcd !== ref_bcd(v) || ov !== (v > 9999) || lat != 17 || be != 0) begin
        n_fail++;
        $display("FAIL random(%0d): bcd %h ovf %b lat %0d be %0d want %h %b 17 0",
                 v, bcd, ov, lat, be, ref_bcd(v), v > 9999);
      end
    end
  endtask

  initial begin
    test_reset();
    test_values("zero", '{0});
    test_values("basic", '{1234, 9999, 1000});
    test_values("ovf", '{10000, 65535, 42});
    test_back_to_back();
    test_reset_mid();
    test_bin12();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
